// File: rtl/i2c_target_if.sv
`timescale 1ns/1ps
// Purpose: bundles the I2C pins and host register port of the i2c_target responder.
// Latency: none, wires only.
// Backpressure: none; the slave side never stretches SCL and the host must take every strobe.
interface i2c_target_if;
   logic       i_scl;            // raw SCL pin level
   logic       i_sda;            // raw SDA pin level
   logic       o_sda;            // 0 = pull SDA low, 1 = release
   logic       o_busy;
   logic       o_write_valid;
   logic [7:0] o_write_register;
   logic [7:0] o_write_data;
   logic [7:0] o_read_register;
   logic [7:0] i_read_data;
   logic       o_read_strobe;

   modport slave (
      input  i_scl, i_sda, i_read_data,
      output o_sda, o_busy, o_write_valid, o_write_register, o_write_data,
             o_read_register, o_read_strobe
   );

   modport master (
      output i_scl, i_sda, i_read_data,
      input  o_sda, o_busy, o_write_valid, o_write_register, o_write_data,
             o_read_register, o_read_strobe
   );
endinterface

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// Purpose: I2C target with 8-bit auto-incrementing register pointer and byte-wide host port.
// Latency: 2-FF sync plus edge compare; bus events act ~3 clocks after the pin edge.
// Backpressure: none; SCL is never stretched, host sees one-cycle write/read strobes.
module i2c_target #(
   parameter logic [6:0] ADDRESS = 7'h54
) (
   input  logic         i_clock,
   input  logic         i_reset,
   i2c_target_if.slave  bus
);
   typedef enum logic [3:0] {
      S_IDLE, S_ADDRESS, S_ADDRESS_ACK, S_IGNORE, S_REGISTER, S_REGISTER_ACK,
      S_WRITE_DATA, S_WRITE_ACK, S_READ_DATA, S_READ_ACK
   } state_t;

   logic       r_scl_meta, r_scl_sync, r_scl_prev;
   logic       r_sda_meta, r_sda_sync, r_sda_prev;
   state_t     r_state, w_state_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   logic       r_rw, w_rw_nxt;
   logic       r_ack_phase, w_ack_phase_nxt;
   logic       r_sda_out, w_sda_out_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_wr_vld, w_wr_vld_nxt;
   logic [7:0] r_wr_reg, w_wr_reg_nxt;
   logic [7:0] r_wr_dat, w_wr_dat_nxt;
   logic [7:0] r_ptr, w_ptr_nxt;
   logic       r_rd_stb, w_rd_stb_nxt;
   logic       r_inc_pend, w_inc_pend_nxt;

   logic       w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0] w_byte;

   // Bring the raw pins into the clock domain; idle bus level is high.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_scl_meta <= 1'b1;
         r_scl_sync <= 1'b1;
         r_scl_prev <= 1'b1;
         r_sda_meta <= 1'b1;
         r_sda_sync <= 1'b1;
         r_sda_prev <= 1'b1;
      end else begin
         r_scl_meta <= bus.i_scl;
         r_scl_sync <= r_scl_meta;
         r_scl_prev <= r_scl_sync;
         r_sda_meta <= bus.i_sda;
         r_sda_sync <= r_sda_meta;
         r_sda_prev <= r_sda_sync;
      end
   end

   // SDA edges only count as START/STOP while SCL is steadily high.
   assign w_scl_rise = r_scl_sync & ~r_scl_prev;
   assign w_scl_fall = ~r_scl_sync & r_scl_prev;
   assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
   assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
   assign w_byte     = {r_shift[6:0], r_sda_sync};

   // Protocol state and all datapath registers.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_shift     <= 8'd0;
         r_rw        <= 1'b0;
         r_ack_phase <= 1'b0;
         r_sda_out   <= 1'b1;
         r_busy      <= 1'b0;
         r_wr_vld    <= 1'b0;
         r_wr_reg    <= 8'd0;
         r_wr_dat    <= 8'd0;
         r_ptr       <= 8'd0;
         r_rd_stb    <= 1'b0;
         r_inc_pend  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_rw        <= w_rw_nxt;
         r_ack_phase <= w_ack_phase_nxt;
         r_sda_out   <= w_sda_out_nxt;
         r_busy      <= w_busy_nxt;
         r_wr_vld    <= w_wr_vld_nxt;
         r_wr_reg    <= w_wr_reg_nxt;
         r_wr_dat    <= w_wr_dat_nxt;
         r_ptr       <= w_ptr_nxt;
         r_rd_stb    <= w_rd_stb_nxt;
         r_inc_pend  <= w_inc_pend_nxt;
      end
   end

   // Next-state decode; START/STOP win over any bit activity in the same cycle.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_shift_nxt     = r_shift;
      w_rw_nxt        = r_rw;
      w_ack_phase_nxt = r_ack_phase;
      w_sda_out_nxt   = r_sda_out;
      w_busy_nxt      = r_busy;
      w_wr_vld_nxt    = 1'b0;
      w_wr_reg_nxt    = r_wr_reg;
      w_wr_dat_nxt    = r_wr_dat;
      w_ptr_nxt       = r_inc_pend ? r_ptr + 8'd1 : r_ptr;
      w_rd_stb_nxt    = 1'b0;
      w_inc_pend_nxt  = 1'b0;

      if (w_start || w_stop) begin
         w_state_nxt     = w_start ? S_ADDRESS : S_IDLE;
         w_cnt_nxt       = 4'd0;
         w_ack_phase_nxt = 1'b0;
         w_sda_out_nxt   = 1'b1;
         w_busy_nxt      = 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_IGNORE: w_sda_out_nxt = 1'b1;
            S_ADDRESS, S_REGISTER, S_WRITE_DATA: begin
               if (w_scl_rise) begin
                  w_shift_nxt = w_byte;
                  w_cnt_nxt   = r_cnt + 4'd1;
                  if (r_cnt == 4'd7) begin
                     w_cnt_nxt = 4'd0;
                     if (r_state == S_ADDRESS) begin
                        if (w_byte[7:1] == ADDRESS) begin
                           w_state_nxt = S_ADDRESS_ACK;
                           w_rw_nxt    = w_byte[0];
                           w_busy_nxt  = 1'b1;
                        end else begin
                           w_state_nxt = S_IGNORE;
                        end
                     end else if (r_state == S_REGISTER) begin
                        w_ptr_nxt   = w_byte;
                        w_state_nxt = S_REGISTER_ACK;
                     end else begin
                        w_wr_vld_nxt   = 1'b1;
                        w_wr_reg_nxt   = r_ptr;
                        w_wr_dat_nxt   = w_byte;
                        w_inc_pend_nxt = 1'b1;
                        w_state_nxt    = S_WRITE_ACK;
                     end
                  end
               end
            end
            S_ADDRESS_ACK, S_REGISTER_ACK, S_WRITE_ACK: begin
               // First falling edge pulls SDA low, second one ends the ACK clock.
               if (w_scl_fall) begin
                  if (!r_ack_phase) begin
                     w_sda_out_nxt   = 1'b0;
                     w_ack_phase_nxt = 1'b1;
                  end else begin
                     w_sda_out_nxt   = 1'b1;
                     w_ack_phase_nxt = 1'b0;
                     w_cnt_nxt       = 4'd0;
                     if (r_state != S_ADDRESS_ACK) begin
                        w_state_nxt = S_WRITE_DATA;
                     end else if (!r_rw) begin
                        w_state_nxt = S_REGISTER;
                     end else begin
                        w_shift_nxt   = bus.i_read_data;
                        w_sda_out_nxt = bus.i_read_data[7];
                        w_rd_stb_nxt  = 1'b1;
                        w_ptr_nxt     = r_ptr + 8'd1;
                        w_state_nxt   = S_READ_DATA;
                     end
                  end
               end
            end
            S_READ_DATA: begin
               // MSB is already on the line; each falling edge presents the next bit.
               if (w_scl_rise) begin
                  w_cnt_nxt = r_cnt + 4'd1;
               end else if (w_scl_fall) begin
                  if (r_cnt == 4'd8) begin
                     w_sda_out_nxt = 1'b1;
                     w_cnt_nxt     = 4'd0;
                     w_state_nxt   = S_READ_ACK;
                  end else begin
                     w_shift_nxt   = {r_shift[6:0], r_shift[7]};
                     w_sda_out_nxt = r_shift[6];
                  end
               end
            end
            S_READ_ACK: begin
               if (w_scl_rise) begin
                  if (r_sda_sync) w_state_nxt = S_IGNORE;
                  else            w_ack_phase_nxt = 1'b1;
               end else if (w_scl_fall && r_ack_phase) begin
                  w_ack_phase_nxt = 1'b0;
                  w_shift_nxt     = bus.i_read_data;
                  w_sda_out_nxt   = bus.i_read_data[7];
                  w_rd_stb_nxt    = 1'b1;
                  w_ptr_nxt       = r_ptr + 8'd1;
                  w_cnt_nxt       = 4'd0;
                  w_state_nxt     = S_READ_DATA;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign bus.o_sda            = r_sda_out;
   assign bus.o_busy           = r_busy;
   assign bus.o_write_valid    = r_wr_vld;
   assign bus.o_write_register = r_wr_reg;
   assign bus.o_write_data     = r_wr_dat;
   assign bus.o_read_register  = r_ptr;
   assign bus.o_read_strobe    = r_rd_stb;
endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// Purpose: directed bus-level bench for i2c_target acting as an I2C master plus register host.
// Latency: SCL runs at 1/40 of the system clock; strobes are logged on the falling clock edge.
// Backpressure: none; the host model answers read_data combinationally from the pointer.
module tb_i2c_target;
   localparam time Q = 100ns;   // quarter SCL period

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic m_scl = 1'b1;
   logic m_sda = 1'b1;

   int checks   = 0;
   int failures = 0;

   int         wr_cnt = 0;
   int         rd_cnt = 0;
   int         wide_cnt = 0;
   logic       wv_prev = 1'b0;
   logic       rs_prev = 1'b0;
   logic [7:0] wr_reg_log [0:15];
   logic [7:0] wr_dat_log [0:15];

   logic       ack;
   logic       b;
   logic [7:0] d;

   i2c_target_if bus();

   assign bus.i_scl       = m_scl;
   assign bus.i_sda       = m_sda & bus.o_sda;
   assign bus.i_read_data = bus.o_read_register + 8'h80;

   i2c_target #(.ADDRESS(7'h54)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5ns clk = ~clk;

   // Log host-port strobes and catch any strobe wider than one cycle.
   always @(negedge clk) begin
      if (bus.o_write_valid) begin
         if (wr_cnt < 16) begin
            wr_reg_log[wr_cnt] = bus.o_write_register;
            wr_dat_log[wr_cnt] = bus.o_write_data;
         end
         wr_cnt++;
      end
      if (bus.o_read_strobe) rd_cnt++;
      if ((bus.o_write_valid && wv_prev) || (bus.o_read_strobe && rs_prev)) wide_cnt++;
      wv_prev = bus.o_write_valid;
      rs_prev = bus.o_read_strobe;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; #Q;
      m_scl = 1'b1; #Q;
      m_sda = 1'b0; #Q;
      m_scl = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; #Q;
      m_scl = 1'b1; #Q;
      m_sda = 1'b1; #Q;
   endtask

   task automatic write_bit(input logic v);
      m_sda = v; #Q;
      m_scl = 1'b1; #(2*Q);
      m_scl = 1'b0; #Q;
   endtask

   task automatic read_bit(output logic v);
      m_sda = 1'b1; #Q;
      m_scl = 1'b1; #Q;
      v = bus.i_sda; #Q;
      m_scl = 1'b0; #Q;
   endtask

   task automatic write_byte(input logic [7:0] v, output logic a);
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      read_bit(a);
   endtask

   task automatic read_byte(output logic [7:0] v, input logic master_ack);
      logic t;
      for (int i = 7; i >= 0; i--) begin
         read_bit(t);
         v[i] = t;
      end
      write_bit(master_ack);
   endtask

   initial begin
      // Reset state
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_sda", bus.o_sda, 1);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_wv", bus.o_write_valid, 0);
      chk("rst_rs", bus.o_read_strobe, 0);
      chk("rst_ptr", bus.o_read_register, 8'h00);
      chk("rst_wreg", bus.o_write_register, 8'h00);
      chk("rst_wdat", bus.o_write_data, 8'h00);
      #Q;

      // Burst write: 54W, reg 10, A5, 5A
      i2c_start();
      write_byte(8'hA8, ack); chk("t1_addr_ack", ack, 0);
      chk("t1_busy", bus.o_busy, 1);
      write_byte(8'h10, ack); chk("t1_reg_ack", ack, 0);
      write_byte(8'hA5, ack); chk("t1_d0_ack", ack, 0);
      write_byte(8'h5A, ack); chk("t1_d1_ack", ack, 0);
      i2c_stop(); #Q;
      chk("t1_busy_stop", bus.o_busy, 0);
      chk("t1_wr_cnt", wr_cnt, 2);
      chk("t1_wreg0", wr_reg_log[0], 8'h10);
      chk("t1_wdat0", wr_dat_log[0], 8'hA5);
      chk("t1_wreg1", wr_reg_log[1], 8'h11);
      chk("t1_wdat1", wr_dat_log[1], 8'h5A);
      chk("t1_ptr", bus.o_read_register, 8'h12);

      // Pointer set then repeated-START burst read
      i2c_start();
      write_byte(8'hA8, ack); chk("t2_addr_ack", ack, 0);
      write_byte(8'h20, ack); chk("t2_reg_ack", ack, 0);
      i2c_start();
      write_byte(8'hA9, ack); chk("t2_raddr_ack", ack, 0);
      read_byte(d, 1'b0);     chk("t2_byte0", d, 8'hA0);
      read_byte(d, 1'b1);     chk("t2_byte1", d, 8'hA1);
      i2c_stop(); #Q;
      chk("t2_rd_cnt", rd_cnt, 2);
      chk("t2_ptr", bus.o_read_register, 8'h22);
      chk("t2_wr_cnt", wr_cnt, 2);

      // Foreign address 55 is ignored
      i2c_start();
      write_byte(8'hAA, ack); chk("t3_nack", ack, 1);
      chk("t3_busy", bus.o_busy, 0);
      write_byte(8'h10, ack); chk("t3_nack2", ack, 1);
      chk("t3_wr_cnt", wr_cnt, 2);
      chk("t3_rd_cnt", rd_cnt, 2);
      i2c_stop(); #Q;

      // Pointer wrap FF -> 00
      i2c_start();
      write_byte(8'hA8, ack); chk("t4_addr_ack", ack, 0);
      write_byte(8'hFF, ack);
      write_byte(8'h11, ack);
      write_byte(8'h22, ack);
      i2c_stop(); #Q;
      chk("t4_wr_cnt", wr_cnt, 4);
      chk("t4_wreg0", wr_reg_log[2], 8'hFF);
      chk("t4_wdat0", wr_dat_log[2], 8'h11);
      chk("t4_wreg1", wr_reg_log[3], 8'h00);
      chk("t4_wdat1", wr_dat_log[3], 8'h22);
      chk("t4_ptr", bus.o_read_register, 8'h01);

      // START aborts a partial address
      i2c_start();
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
      i2c_start();
      write_byte(8'hA8, ack); chk("t5_addr_ack", ack, 0);
      write_byte(8'h03, ack);
      write_byte(8'h77, ack); chk("t5_d_ack", ack, 0);
      i2c_stop(); #Q;
      chk("t5_wr_cnt", wr_cnt, 5);
      chk("t5_wreg", wr_reg_log[4], 8'h03);
      chk("t5_wdat", wr_dat_log[4], 8'h77);

      // Reset while the target drives a 0 read bit (byte 84: bit6 = 0)
      i2c_start();
      write_byte(8'hA9, ack); chk("t6_addr_ack", ack, 0);
      chk("t6_rd_cnt", rd_cnt, 3);
      read_bit(b);            chk("t6_bit7", b, 1);
      chk("t6_drive0", bus.o_sda, 0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_sda", bus.o_sda, 1);
      chk("t6_rst_busy", bus.o_busy, 0);
      chk("t6_rst_ptr", bus.o_read_register, 8'h00);
      rst = 1'b0;
      #Q;
      i2c_stop(); #Q;
      i2c_start();
      write_byte(8'hA8, ack); chk("t6_re_ack", ack, 0);
      write_byte(8'h5A, ack);
      write_byte(8'h3C, ack); chk("t6_re_d_ack", ack, 0);
      i2c_stop(); #Q;
      chk("t6_wr_cnt", wr_cnt, 6);
      chk("t6_wreg", wr_reg_log[5], 8'h5A);
      chk("t6_wdat", wr_dat_log[5], 8'h3C);
      chk("t6_ptr", bus.o_read_register, 8'h5B);
      chk("strobe_width", wide_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
